retro_bram_arbiter: RTL

//  Shares one single-port, one-cycle BRAM (RetroBRAM target port) between Ports requesters, e.g. CPU, PPU/VDP, DMA.

---
 rtl/retro_bram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/retro_bram_arbiter.sv
// Shares one single-port, one-cycle BRAM between several requesters: round-robin grant,
// optional fixed-priority port, anti-starvation timer, read data routed back one cycle later.
module retro_bram_arbiter #(
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int Ports           = 2,
  parameter int PriorityPort    = -1,
  parameter int MaxWait         = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [Ports-1:0]                  ReqAccess,
  input  logic [Ports*DataBusWidth-1:0]     ReqWrite,
  input  logic [Ports*AddressBusWidth-1:0]  ReqAddress,
  input  logic [Ports*8*DataBusWidth-1:0]   ReqDin,
  output logic [Ports-1:0]                  ReqReady,
  output logic [Ports-1:0]                  ReqDataReady,
  output logic [8*DataBusWidth-1:0]         ReqDout,
  output logic                              MemAccess,
  output logic [DataBusWidth-1:0]           MemWrite,
  output logic [AddressBusWidth-1:0]        MemAddress,
  output logic [8*DataBusWidth-1:0]         MemDin,
  input  logic [8*DataBusWidth-1:0]         MemDout
);

  localparam int PtrW = $clog2(Ports);
  localparam int CntW = $clog2(MaxWait + 1);
  localparam bit PrioEn = (PriorityPort >= 0) && (PriorityPort < Ports);
  localparam logic [PtrW-1:0] PrioPtr = PrioEn ? PtrW'(PriorityPort) : '0;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Ports - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxWait);

  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  wait_cnt_q [Ports];
  logic [CntW-1:0]  wait_cnt_d [Ports];
  logic [Ports-1:0] rd_tag_q, rd_tag_d;

  logic [Ports-1:0] starving_s, grant_s;
  logic [PtrW:0]    st_pick_s, rr_pick_s;
  logic [PtrW-1:0]  win_idx_s;
  logic             win_valid_s, win_rr_s;

  // First set bit of mask at or after ptr, wrapping; returns {found, index}.
  function automatic logic [PtrW:0] rr_pick(input logic [Ports-1:0] mask, input logic [PtrW-1:0] ptr);
    logic          found;
    logic [PtrW-1:0] sel;
    logic [PtrW:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < Ports; k++) begin
      idx = {1'b0, ptr} + (PtrW+1)'(k);
      idx = (idx >= (PtrW+1)'(Ports)) ? idx - (PtrW+1)'(Ports) : idx;
      if (!found && mask[idx[PtrW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PtrW-1:0];
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    starving_s = '0;
    for (int i = 0; i < Ports; i++) begin
      starving_s[i] = ReqAccess[i] && (wait_cnt_q[i] >= MaxCnt) && !(PrioEn && (i == PriorityPort));
    end
  end

  assign st_pick_s = rr_pick(starving_s, rr_ptr_q);
  assign rr_pick_s = rr_pick(ReqAccess, rr_ptr_q);

  // Winner: starved port, then priority port, then round-robin; nothing while in reset.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    win_rr_s    = 1'b0;
    if (Reset) begin
      win_valid_s = 1'b0;
    end else if (st_pick_s[PtrW]) begin
      win_valid_s = 1'b1;
      win_idx_s   = st_pick_s[PtrW-1:0];
      win_rr_s    = 1'b1;
    end else if (PrioEn && ReqAccess[PrioPtr]) begin
      win_valid_s = 1'b1;
      win_idx_s   = PrioPtr;
    end else if (rr_pick_s[PtrW]) begin
      win_valid_s = 1'b1;
      win_idx_s   = rr_pick_s[PtrW-1:0];
      win_rr_s    = 1'b1;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // One-hot grant drives an AND-OR mux of the winner's request fields.
  always_comb begin
    grant_s    = '0;
    MemWrite   = '0;
    MemAddress = '0;
    MemDin     = '0;
    for (int i = 0; i < Ports; i++) begin
      grant_s[i] = win_valid_s && (win_idx_s == PtrW'(i));
      MemWrite   = MemWrite   | ({DataBusWidth{grant_s[i]}}    & ReqWrite[i*DataBusWidth +: DataBusWidth]);
      MemAddress = MemAddress | ({AddressBusWidth{grant_s[i]}} & ReqAddress[i*AddressBusWidth +: AddressBusWidth]);
      MemDin     = MemDin     | ({8*DataBusWidth{grant_s[i]}}  & ReqDin[i*8*DataBusWidth +: 8*DataBusWidth]);
    end
  end

  assign ReqReady     = grant_s;
  assign MemAccess    = |grant_s;
  assign ReqDataReady = rd_tag_q;
  assign ReqDout      = MemDout;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_valid_s && win_rr_s) begin
      rr_ptr_d = (win_idx_s == LastPtr) ? '0 : win_idx_s + PtrW'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    rd_tag_d = grant_s & {Ports{MemWrite == '0}};
    for (int i = 0; i < Ports; i++) begin
      if ((PrioEn && (i == PriorityPort)) || !ReqAccess[i] || grant_s[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] < MaxCnt) begin
        wait_cnt_d[i] = wait_cnt_q[i] + CntW'(1);
      end else begin
        wait_cnt_d[i] = wait_cnt_q[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q <= '0;
      rd_tag_q <= '0;
      for (int i = 0; i < Ports; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_tag_q <= rd_tag_d;
      for (int i = 0; i < Ports; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  retro_bram_arbiter_chk #(
    .Ports        (Ports),
    .PriorityPort (PriorityPort)
  ) u_chk (
    .Clk   (Clk),
    .Reset (Reset)
  );

endmodule

// Flags a PriorityPort index that does not exist; such a value behaves as pure round-robin.
module retro_bram_arbiter_chk #(
  parameter int Ports        = 2,
  parameter int PriorityPort = -1
) (
  input logic Clk,
  input logic Reset
);

  localparam bit PrioOutOfRange = (PriorityPort >= Ports);

  always @(posedge Clk) begin
    if (!Reset) begin
      assert (!PrioOutOfRange);
    end
  end

endmodule
